vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single BRAM port of the text-mode VRAM (600 words plus control register at word 600) between two requesters: the display fetch path and the AXI host path.
- Fixed priority goes to display. A starvation counter guarantees the host progress.
- Owns the control register, tracks in-flight reads through the BRAM read latency, and steers read data back to the requester that issued the read.

Parameters:
ADDR_W, 11, word address width
DATA_W, 32, data width
RD_LAT, 2, BRAM read latency in cycles (1..4)
STARVE_MAX, 8, consecutive host denials before a forced host grant (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
disp_req  in  1  display access request, held until granted
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display grant, combinational, same cycle
disp_rvalid  out  1  display read data valid
disp_rdata  out  DATA_W  display read data
host_req  in  1  host access request, held until granted
host_we  in  4  host byte write enables; 0 means read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host grant, combinational, same cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
bram_en  out  1  BRAM port enable
bram_we  out  4  BRAM byte write enables
bram_addr  out  ADDR_W  BRAM address
bram_din  out  DATA_W  BRAM write data
bram_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after bram_en
ctrl_out  out  DATA_W  control register contents

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values: all grants 0, all rvalids 0, all rdata 0, bram_en 0, bram_we 0, ctrl_out 0, starvation counter 0, FSM in NORMAL.

Arbitration:
- At most one grant per cycle.
- Display is a read-only requester; it never writes.
- FSM states and transitions:
  - NORMAL: display wins if disp_req. Otherwise host wins if host_req.
  - NORMAL, counter: increments when host_req=1 and the host is not granted; clears whenever the host is granted. When the counter reaches STARVE_MAX, go to BOOST.
  - BOOST: host wins if host_req, even if disp_req=1. Return to NORMAL the next cycle and clear the counter.
  - BOOST with host_req=0 (host withdrew): return to NORMAL and behave as NORMAL that cycle.

Address decode, per granted access:
- addr < 600: BRAM access. bram_en=1, bram_addr=addr. For host writes, bram_we=host_we and bram_din=host_wdata.
- addr == 600 (control register):
  - No BRAM access; bram_en=0.
  - Host write updates the control register bytewise per host_we, visible on ctrl_out the next cycle.
  - Read returns the control register.
- addr > 600: no BRAM access. Writes are dropped; reads return 0.

Read return:
- Every granted read produces exactly one rvalid pulse, on the owner's port only, exactly RD_LAT cycles after the grant.
- This applies to control-register and out-of-range reads too, so latency is uniform.
- Control-register read data is the register value sampled at grant time.
- rdata holds its last value while rvalid=0.
- Writes produce no rvalid.
- Back-to-back grants are fully pipelined: one read returns per cycle.

Boundary conditions:
- Simultaneous host write to 600 and display read of 600 (display granted): the display sees the old value; the host write lands when the host is later granted.
- Reset mid-operation: in-flight read tags are discarded, and no rvalid is produced after reset deasserts for reads granted before reset.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs stat_host_gnt[15:0] and stat_boost[15:0].
  - stat_host_gnt counts host grants; stat_boost counts BOOST entries.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vram_arb_pkg:
  - owner_e enum: OWN_NONE, OWN_DISP, OWN_HOST.
  - arb_state_e enum: NORMAL, BOOST.
  - Constants CTRL_ADDR=600 and VRAM_WORDS=600.
  - rd_tag_t struct: valid, owner_e owner, src_sel (BRAM/CTRL/ZERO), ctrl snapshot.
- Sub-module rd_tag_pipe: an RD_LAT-deep shift register of rd_tag_t with async reset. The top-level muxes its output stage with bram_dout to form rdata.

Test Plan:
- Host write 0x12345678 to addr 5 (we=F), later display read addr 5 -> bram_we=F at addr 5; disp_rvalid 2 cycles after disp_gnt with rdata=0x12345678.
- Host write 0xA5A5A5A5 to addr 600 with we=4'b0011, then host read addr 600 -> ctrl_out=0x0000A5A5 the next cycle; host_rvalid after 2 cycles with 0x0000A5A5; bram_en=0 throughout.
- disp_req and host_req both held high for 20 cycles -> host_gnt on cycles 9 and 18 only; display granted on all other cycles.
- Host read addr 700 -> host_rvalid after 2 cycles with rdata=0, bram_en=0. Host write addr 700 -> no state change.
- Alternating granted reads: display addr 1, host addr 2, display addr 3 on consecutive cycles -> rvalids land on the correct ports in that order, 2 cycles after each grant.
- Assert reset one cycle after a granted read -> no rvalid afterwards; ctrl_out=0 and all outputs at reset values.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the text-mode VRAM arbiter (package vram_arb_pkg).
// Read-tag layout, requester ownership, FSM encoding and control-register byte merge.
package vram_arb_pkg;

  localparam int VRAM_WORDS = 600;
  localparam int CTRL_ADDR  = 600;
  localparam int CTRL_W     = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    BOOST  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_BRAM = 2'd0,
    SRC_CTRL = 2'd1,
    SRC_ZERO = 2'd2
  } src_sel_e;

  typedef struct packed {
    logic              valid;
    owner_e            owner;
    src_sel_e          src_sel;
    logic [CTRL_W-1:0] ctrl;
  } rd_tag_t;

  function automatic logic [CTRL_W-1:0] byte_merge(input logic [CTRL_W-1:0] old_v,
                                                    input logic [CTRL_W-1:0] new_v,
                                                    input logic [3:0]        we);
    logic [CTRL_W-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else       res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester, BRAM and control-register signals of the VRAM arbiter.
// ARB_STATS_EN adds the grant/boost statistics counters.
interface vram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              host_req;
  logic [3:0]        host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] ctrl_out;
`ifdef ARB_STATS_EN
  logic [15:0]       stat_host_gnt;
  logic [15:0]       stat_boost;
`endif

  modport master (
    output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, bram_dout,
    input  disp_gnt, disp_rvalid, disp_rdata, host_gnt, host_rvalid, host_rdata,
           bram_en, bram_we, bram_addr, bram_din, ctrl_out
`ifdef ARB_STATS_EN
           , stat_host_gnt, stat_boost
`endif
  );

  modport slave (
    input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, bram_dout,
    output disp_gnt, disp_rvalid, disp_rdata, host_gnt, host_rvalid, host_rdata,
           bram_en, bram_we, bram_addr, bram_din, ctrl_out
`ifdef ARB_STATS_EN
           , stat_host_gnt, stat_boost
`endif
  );
endinterface

// File: rtl/vram_arbiter_rd_tag_pipe.sv
// Read-tag delay line matching the BRAM read latency; the last stage
// tells the top which requester owns the data arriving on bram_dout.
module rd_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t stage_r [DEPTH];

  // Shift tags one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign tag_out = stage_r[DEPTH-1];
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display-priority with starvation boost for the host,
// control register at word 600, latency-matched read return. Option: ARB_STATS_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam logic [0:0] S_NORMAL = NORMAL;
  localparam logic [0:0] S_BOOST  = BOOST;

  logic [0:0]        state_r;
  logic [7:0]        starve_r;
  logic [DATA_W-1:0] ctrl_r, disp_hold_r, host_hold_r, ret_data_s;
  logic              disp_gnt_s, host_gnt_s, any_gnt_s, host_wr_s;
  logic              in_vram_s, is_ctrl_s, boost_entry_s, disp_ret_s, host_ret_s;
  logic [ADDR_W-1:0] addr_s;
  rd_tag_t           tag_in_s, tag_out_s;

  // Arbitration: boosted host first, then display, then host; nothing in reset.
  always_comb begin
    disp_gnt_s = 1'b0;
    host_gnt_s = 1'b0;
    if (reset) begin
      host_gnt_s = 1'b0;
    end else if (state_r == S_BOOST && bus.host_req) begin
      host_gnt_s = 1'b1;
    end else if (bus.disp_req) begin
      disp_gnt_s = 1'b1;
    end else if (bus.host_req) begin
      host_gnt_s = 1'b1;
    end else begin
      disp_gnt_s = 1'b0;
    end
  end

  assign any_gnt_s     = disp_gnt_s | host_gnt_s;
  assign addr_s        = host_gnt_s ? bus.host_addr : bus.disp_addr;
  assign host_wr_s     = host_gnt_s && (bus.host_we != 4'd0);
  assign in_vram_s     = addr_s < ADDR_W'(VRAM_WORDS);
  assign is_ctrl_s     = addr_s == ADDR_W'(CTRL_ADDR);
  assign boost_entry_s = (state_r == S_NORMAL) && !host_gnt_s && bus.host_req &&
                         (starve_r == 8'(STARVE_MAX - 1));

  assign bus.disp_gnt  = disp_gnt_s;
  assign bus.host_gnt  = host_gnt_s;
  assign bus.bram_en   = any_gnt_s && in_vram_s;
  assign bus.bram_addr = (any_gnt_s && in_vram_s) ? addr_s : '0;
  assign bus.bram_we   = (host_wr_s && in_vram_s) ? bus.host_we : 4'd0;
  assign bus.bram_din  = (host_wr_s && in_vram_s) ? bus.host_wdata : '0;
  assign bus.ctrl_out  = ctrl_r;

  // Tag every granted read so its data can be steered back RD_LAT cycles later.
  always_comb begin
    tag_in_s       = '0;
    tag_in_s.valid = any_gnt_s && !host_wr_s;
    tag_in_s.ctrl  = ctrl_r;
    if (host_gnt_s)      tag_in_s.owner = OWN_HOST;
    else if (disp_gnt_s) tag_in_s.owner = OWN_DISP;
    else                 tag_in_s.owner = OWN_NONE;
    if (in_vram_s)       tag_in_s.src_sel = SRC_BRAM;
    else if (is_ctrl_s)  tag_in_s.src_sel = SRC_CTRL;
    else                 tag_in_s.src_sel = SRC_ZERO;
  end

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // Select returning data by the source recorded at grant time.
  always_comb begin
    ret_data_s = '0;
    case (tag_out_s.src_sel)
      SRC_BRAM: ret_data_s = bus.bram_dout;
      SRC_CTRL: ret_data_s = tag_out_s.ctrl;
      default:  ret_data_s = '0;
    endcase
  end

  assign disp_ret_s      = tag_out_s.valid && (tag_out_s.owner == OWN_DISP);
  assign host_ret_s      = tag_out_s.valid && (tag_out_s.owner == OWN_HOST);
  assign bus.disp_rvalid = disp_ret_s;
  assign bus.host_rvalid = host_ret_s;
  assign bus.disp_rdata  = disp_ret_s ? ret_data_s : disp_hold_r;
  assign bus.host_rdata  = host_ret_s ? ret_data_s : host_hold_r;

  // Starvation FSM: BOOST lasts exactly one cycle whether or not the host uses it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_NORMAL;
      starve_r <= 8'd0;
    end else if (state_r == S_BOOST) begin
      state_r  <= S_NORMAL;
      starve_r <= 8'd0;
    end else if (host_gnt_s) begin
      starve_r <= 8'd0;
    end else if (bus.host_req) begin
      starve_r <= starve_r + 8'd1;
      if (boost_entry_s) state_r <= S_BOOST;
    end
  end

  // Control register takes host byte writes to word 600.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ctrl_r <= '0;
    else if (host_wr_s && is_ctrl_s) ctrl_r <= byte_merge(ctrl_r, bus.host_wdata, bus.host_we);
  end

  // Per-port rdata holding between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_hold_r <= '0;
      host_hold_r <= '0;
    end else begin
      if (disp_ret_s) disp_hold_r <= ret_data_s;
      if (host_ret_s) host_hold_r <= ret_data_s;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stat_host_r, stat_boost_r;

  // Saturating grant and boost-entry counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_host_r  <= 16'd0;
      stat_boost_r <= 16'd0;
    end else begin
      if (host_gnt_s && stat_host_r != 16'hFFFF)     stat_host_r  <= stat_host_r + 16'd1;
      if (boost_entry_s && stat_boost_r != 16'hFFFF) stat_boost_r <= stat_boost_r + 16'd1;
    end
  end

  assign bus.stat_host_gnt = stat_host_r;
  assign bus.stat_boost    = stat_boost_r;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized, model-checked bench for vram_arbiter plus directed scenarios
// with hand-computed expectations.
module tb_vram_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  vram_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] m;
    m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  // BRAM with RD_LAT-cycle read latency, read-first
  logic [31:0] bram_mem  [600]    = '{default: 32'h0};
  logic [31:0] bram_pipe [RD_LAT] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_addr < 11'd600) begin
      bram_pipe[0] <= bram_mem[bus.bram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) bram_mem[bus.bram_addr][8*b +: 8] <= bus.bram_din[8*b +: 8];
    end else begin
      bram_pipe[0] <= 32'hDEAD_BEEF;
    end
    for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bus.bram_dout = bram_pipe[RD_LAT-1];

  // Reference model: starvation as a count of denials, returns as a due-cycle queue.
  typedef struct { int due; bit host; logic [31:0] data; } ret_t;
  ret_t        ret_q[$];
  int          cyc = 0;
  int          denials = 0;
  logic [31:0] ref_ctrl = 32'h0, hold_d = 32'h0, hold_h = 32'h0;
  logic [31:0] ref_mem [600] = '{default: 32'h0};

  always @(negedge clk) begin : compare
    bit          eg_d, eg_h, ev_d, ev_h, boost, en;
    logic [10:0] a;
    logic [3:0]  we;
    logic [31:0] rd;
    ret_t        r;
    cyc++;
    if (reset) begin
      ret_q.delete();
      denials = 0; ref_ctrl = 32'h0; hold_d = 32'h0; hold_h = 32'h0;
      chk("rst_disp_gnt", bus.disp_gnt, 0);
      chk("rst_host_gnt", bus.host_gnt, 0);
      chk("rst_disp_rvalid", bus.disp_rvalid, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_disp_rdata", bus.disp_rdata, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      chk("rst_bram_en", bus.bram_en, 0);
      chk("rst_bram_we", bus.bram_we, 0);
      chk("rst_ctrl_out", bus.ctrl_out, 0);
    end else begin
      boost = (denials >= STARVE_MAX);
      eg_h  = bus.host_req && (boost || !bus.disp_req);
      eg_d  = bus.disp_req && !eg_h;
      if (eg_h || boost)     denials = 0;
      else if (bus.host_req) denials++;
      ev_d = 1'b0; ev_h = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        if (r.host) begin ev_h = 1'b1; hold_h = r.data; end
        else        begin ev_d = 1'b1; hold_d = r.data; end
      end
      chk("disp_gnt", bus.disp_gnt, eg_d);
      chk("host_gnt", bus.host_gnt, eg_h);
      chk("disp_rvalid", bus.disp_rvalid, ev_d);
      chk("host_rvalid", bus.host_rvalid, ev_h);
      chk("disp_rdata", bus.disp_rdata, hold_d);
      chk("host_rdata", bus.host_rdata, hold_h);
      chk("ctrl_out", bus.ctrl_out, ref_ctrl);
      if (eg_d || eg_h) begin
        a  = eg_h ? bus.host_addr : bus.disp_addr;
        we = eg_h ? bus.host_we : 4'd0;
        en = (a < 11'd600);
        chk("bram_en", bus.bram_en, en);
        chk("bram_we", bus.bram_we, en ? we : 4'd0);
        if (en) chk("bram_addr", bus.bram_addr, a);
        if (en && we != 4'd0) chk("bram_din", bus.bram_din, bus.host_wdata);
        if (we == 4'd0) begin
          rd = (a < 11'd600) ? ref_mem[a] : (a == 11'd600) ? ref_ctrl : 32'h0;
          ret_q.push_back('{due: cyc + RD_LAT, host: eg_h, data: rd});
        end else if (a < 11'd600) ref_mem[a] = merge(ref_mem[a], bus.host_wdata, we);
        else if (a == 11'd600)    ref_ctrl   = merge(ref_ctrl, bus.host_wdata, we);
      end else begin
        chk("bram_en_idle", bus.bram_en, 0);
      end
    end
  end

  logic        cap_en;
  logic [3:0]  cap_we;
  logic [10:0] cap_addr;

  // Raise one request and hold it until granted (bounded); returns at posedge+1 after the grant.
  task automatic req_op(input bit host, input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
    bit got = 1'b0;
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    end else begin
      bus.disp_req = 1'b1; bus.disp_addr = a;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (host ? bus.host_gnt : bus.disp_gnt) begin
        got = 1'b1; cap_en = bus.bram_en; cap_we = bus.bram_we; cap_addr = bus.bram_addr;
      end
      @(posedge clk); #1;
    end
    if (host) bus.host_req = 1'b0;
    else      bus.disp_req = 1'b0;
    chk("grant_wait", got, 1);
  endtask

  function automatic logic [10:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 80)      return 11'($urandom_range(0, 15));
    else if (r < 88) return 11'd600;
    else if (r < 94) return 11'($urandom_range(601, 2047));
    else             return 11'($urandom_range(16, 599));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hmask;
    int          dcnt, vcnt;
    bit          dg, hg;
    reset = 1'b1;
    bus.disp_req = 1'b0; bus.disp_addr = 11'd0;
    bus.host_req = 1'b0; bus.host_we = 4'd0; bus.host_addr = 11'd0; bus.host_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Host write then display read of word 5
    req_op(1'b1, 4'hF, 11'd5, 32'h1234_5678);
    chk("t1_we", cap_we, 4'hF);
    chk("t1_addr", cap_addr, 11'd5);
    req_op(1'b0, 4'd0, 11'd5, 32'h0);
    @(negedge clk); chk("t1_rvalid_early", bus.disp_rvalid, 0);
    @(negedge clk); chk("t1_rvalid", bus.disp_rvalid, 1);
    chk("t1_rdata", bus.disp_rdata, 32'h1234_5678);

    // Control register byte write and read-back
    req_op(1'b1, 4'b0011, 11'd600, 32'hA5A5_A5A5);
    chk("t2_wr_bram_en", cap_en, 0);
    @(negedge clk); chk("t2_ctrl_out", bus.ctrl_out, 32'h0000_A5A5);
    @(posedge clk); #1;
    req_op(1'b1, 4'd0, 11'd600, 32'h0);
    chk("t2_rd_bram_en", cap_en, 0);
    @(negedge clk);
    @(negedge clk); chk("t2_rvalid", bus.host_rvalid, 1);
    chk("t2_rdata", bus.host_rdata, 32'h0000_A5A5);
    @(posedge clk); #1;

    // Both requesting for 20 cycles: host only on cycles 9 and 18
    bus.disp_req = 1'b1; bus.disp_addr = 11'd10;
    bus.host_req = 1'b1; bus.host_we = 4'd0; bus.host_addr = 11'd5;
    hmask = 32'h0; dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.host_gnt) hmask = hmask | (32'h1 << i);
      if (bus.disp_gnt) dcnt++;
      @(posedge clk); #1;
    end
    bus.disp_req = 1'b0; bus.host_req = 1'b0;
    chk("t3_host_cycles", hmask, 32'h0002_0100);
    chk("t3_disp_count", dcnt, 18);
    repeat (3) @(posedge clk); #1;

    // Out-of-range read returns zero, write leaves state alone
    req_op(1'b1, 4'd0, 11'd700, 32'h0);
    chk("t4_bram_en", cap_en, 0);
    @(negedge clk);
    @(negedge clk); chk("t4_rvalid", bus.host_rvalid, 1);
    chk("t4_rdata", bus.host_rdata, 32'h0);
    @(posedge clk); #1;
    req_op(1'b1, 4'hF, 11'd700, 32'hFFFF_FFFF);
    chk("t4_wr_bram_en", cap_en, 0);
    @(negedge clk); chk("t4_ctrl_kept", bus.ctrl_out, 32'h0000_A5A5);
    @(posedge clk); #1;

    // Interleaved reads return on the right ports in order
    req_op(1'b1, 4'hF, 11'd1, 32'h1111_1111);
    req_op(1'b1, 4'hF, 11'd2, 32'h2222_2222);
    req_op(1'b1, 4'hF, 11'd3, 32'h3333_3333);
    bus.disp_req = 1'b1; bus.disp_addr = 11'd1;
    bus.host_req = 1'b1; bus.host_we = 4'd0; bus.host_addr = 11'd2;
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    @(posedge clk); #1;
    bus.host_req = 1'b0; bus.disp_req = 1'b1; bus.disp_addr = 11'd3;
    @(negedge clk);
    chk("t5_d1_valid", bus.disp_rvalid, 1); chk("t5_d1_h", bus.host_rvalid, 0);
    chk("t5_d1_data", bus.disp_rdata, 32'h1111_1111);
    @(posedge clk); #1; bus.disp_req = 1'b0;
    @(negedge clk);
    chk("t5_h2_valid", bus.host_rvalid, 1); chk("t5_h2_d", bus.disp_rvalid, 0);
    chk("t5_h2_data", bus.host_rdata, 32'h2222_2222);
    @(negedge clk);
    chk("t5_d3_valid", bus.disp_rvalid, 1);
    chk("t5_d3_data", bus.disp_rdata, 32'h3333_3333);
    @(posedge clk); #1;

    // Reset one cycle after a granted read: nothing comes back
    req_op(1'b1, 4'd0, 11'd5, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ctrl_out", bus.ctrl_out, 32'h0);
    chk("t6_host_rdata", bus.host_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      vcnt += int'(bus.host_rvalid) + int'(bus.disp_rvalid);
    end
    chk("t6_no_rvalid", vcnt, 0);
    @(posedge clk); #1;

    // Random traffic obeying hold-until-granted
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      dg = bus.disp_gnt; hg = bus.host_gnt;
      @(posedge clk); #1;
      reset = (i == 700);
      if (!bus.disp_req || dg) begin
        bus.disp_req  = ($urandom_range(0, 99) < 50);
        bus.disp_addr = rand_addr();
      end
      if (!bus.host_req || hg) begin
        bus.host_req   = ($urandom_range(0, 99) < 45);
        bus.host_we    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        bus.host_addr  = rand_addr();
        bus.host_wdata = $urandom;
      end
    end
    bus.disp_req = 1'b0; bus.host_req = 1'b0; reset = 1'b0;
    repeat (RD_LAT + 3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
